// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC / instruction-fetch stage.
package pc_fetch_unit_pkg;

  // Next-PC select codes driven by the control unit
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Fetch FSM states; local to this stage, exported only for observation
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection and alignment check.
module npc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        branch_taken,
  input  logic [31:0] imm32,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // Select the next PC; branch offset is a word offset, all sums wrap mod 2^32
  always_comb begin
    next_pc = pc_plus4;
    case (npc_op)
      NPC_PLUS4:  next_pc = pc_plus4;
      NPC_BRANCH: next_pc = branch_taken ? (pc_plus4 + (imm32 << 2)) : pc_plus4;
      NPC_JUMP:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      NPC_JR:     next_pc = reg_target;
      default:    next_pc = pc_plus4;
    endcase
  end

  // Only a JR target can be misaligned, but the check covers whatever was selected
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: IDLE -> FETCH -> EXEC -> FETCH ...,
// with a terminal HALT state left only through reset.
//
// Instruction-memory handshake: IMemReq is held high for the whole FETCH state with
// IMemAddr stable; the memory may wait any number of cycles and signals completion
// by raising IMemAck for one cycle with IMemRdata valid. A transfer happens on a
// rising edge where IMemReq && IMemAck. IMemAck seen while IMemReq is low is ignored.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   NPCOp,
  input  logic         BranchTaken,
  input  logic [31:0]  Immediate32,
  input  logic [25:0]  JumpIndex,
  input  logic [31:0]  RegTarget,
  input  logic         Stall,
  input  logic         Halt,
  output logic         IMemReq,
  output logic [31:0]  IMemAddr,
  input  logic [31:0]  IMemRdata,
  input  logic         IMemAck,
  output logic [31:0]  PC,
  output logic [31:0]  PCPlus4,
  output logic [31:0]  Instr,
  output logic         InstrValid,
  output logic         AddrErr,
  output logic         Halted,
  output fetch_state_t fsm_state
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_q, instr_q;
  logic         addr_err_q;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         load_instr, load_pc, set_err;

  npc_calc u_npc_calc (
    .pc           (pc_q),
    .npc_op       (NPCOp),
    .branch_taken (BranchTaken),
    .imm32        (Immediate32),
    .jump_index   (JumpIndex),
    .reg_target   (RegTarget),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  // Next-state and register-load decode; EXEC priority is Stall > Halt > misaligned > advance
  always_comb begin
    state_next = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (IMemAck) begin
          load_instr = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (Stall) begin
          state_next = ST_EXEC;
        end else if (Halt) begin
          state_next = ST_HALT;
        end else if (misaligned) begin
          set_err    = 1'b1;
          state_next = ST_HALT;
        end else begin
          load_pc    = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, PC, instruction and sticky error registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (load_instr) instr_q    <= IMemRdata;
      if (load_pc)    pc_q       <= next_pc;
      if (set_err)    addr_err_q <= 1'b1;
    end
  end

  // Outputs decoded purely from registered state, so no input reaches an output combinationally
  assign IMemReq    = (state == ST_FETCH);
  assign IMemAddr   = pc_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign Instr      = instr_q;
  assign InstrValid = (state == ST_EXEC);
  assign Halted     = (state == ST_HALT);
  assign AddrErr    = addr_err_q;
  assign fsm_state  = state;

endmodule
